mem_bus_master: RTL and testbench
=================================

// Module: mem_bus_master
// PURPOSE
//   Bus initiator between the CPU load/store path and the synchronous block RAM. It also serves the memory-mapped I/O words.
//   - Accepts one word request at a time over a valid/ready handshake.
//   - Drives the RAM port (address, write value, write enable) and absorbs the RAM's 1-cycle registered read latency.
//   - Decodes the I/O window: switches, buttons and the accumulator register used by the calculator programme.
//   - Returns read data or write completion as a single-cycle response pulse.
// PARAMETERS
//   MEM_SIZE   1024      RAM depth in 32-bit words; RAM region is 0 .. MEM_SIZE-1
//   IO_BASE    20'h01000 switches @IO_BASE, buttons @IO_BASE+1, accum @IO_BASE+2
//   SW_WIDTH   16        switch input width, zero-extended to 32 bits
//   BTN_WIDTH  4         button input width, zero-extended to 32 bits
// PORTS
//   clk               in   1         rising-edge clock
//   rst_n             in   1         asynchronous, active-low reset
//   req_valid         in   1         CPU request present
//   req_ready         out  1         block can accept; high only in IDLE
//   req_write         in   1         1 = store, 0 = load
//   req_address       in   20        word address
//   req_wdata         in   32        store data
//   rsp_valid         out  1         one-cycle pulse: load data valid / store done
//   rsp_rdata         out  32        load data; 0 for stores and unmapped reads
//   mem_address       out  20        RAM address
//   mem_write_value   out  32        RAM write data
//   mem_write_enable  out  1         RAM write strobe
//   mem_read_value    in   32        RAM read data, valid 1 cycle after address is sampled
//   io_switches       in   SW_WIDTH  asynchronous switch inputs
//   io_buttons        in   BTN_WIDTH asynchronous button inputs
//   io_accum          out  32        accumulator register value, for display
// BEHAVIOUR
//   Reset
//   - Async assert forces: state=IDLE; rsp_valid=0; rsp_rdata=0; mem_address=0; mem_write_value=0; mem_write_enable=0.
//   - Also clears io_accum and the synchroniser flops to 0. req_ready=1 while in reset and after release.
//   Handshake
//   - A transfer is accepted on a clock edge where req_valid && req_ready.
//   - Request fields are captured at that edge. Inputs are ignored at all other times.
//   - Exactly one rsp_valid pulse is issued per accepted request.
//   Decode (on captured address)
//   - RAM:      address < MEM_SIZE.
//   - IO:       IO_BASE .. IO_BASE+2.
//   - Unmapped: anything else.
//   FSM: IDLE, WR, RD_ISSUE, RD_WAIT, RESP. All outputs are registered except req_ready = (state==IDLE).
//   - IDLE -> WR on an accepted RAM store.
//       mem_address and mem_write_value are loaded with the request; mem_write_enable=1 for the WR cycle only.
//   - WR -> RESP (the RAM performs the write at this edge).
//   - IDLE -> RD_ISSUE on an accepted RAM load; mem_address is loaded.
//   - RD_ISSUE -> RD_WAIT (the RAM samples the address at this edge).
//   - RD_WAIT -> RESP; rsp_rdata <= mem_read_value.
//   - IDLE -> RESP on IO or unmapped requests. Register updates at the accept edge:
//       load switches: rsp_rdata <= zero-extended synchronised switches.
//       load buttons:  rsp_rdata <= zero-extended synchronised buttons.
//       load accum:    rsp_rdata <= io_accum.
//       store accum:   io_accum <= req_wdata; rsp_rdata <= 0.
//       stores to switches/buttons and all unmapped accesses: dropped, rsp_rdata <= 0, no error or hang.
//   - RESP: rsp_valid=1 for exactly this cycle -> IDLE.
//   Latency (rsp_valid high in cycle N after the accept cycle)
//   - RAM load N=3; RAM store N=2; IO/unmapped N=1.
//   - Minimum request spacing = latency + 1 (request accepted again only from IDLE).
//   RAM port rules
//   - mem_address/mem_write_value change only when a RAM access is accepted; they hold their last value otherwise.
//     IO and unmapped addresses never reach the RAM.
//   - mem_write_enable is never high outside WR; at most one write strobe per request.
//   Synchronisers
//   - io_switches and io_buttons pass through 2-flop synchronisers; a change is readable 2 edges later.
//   Reset mid-operation
//   - Aborts the transfer with no rsp_valid.
//   - Reset asserted during WR drops mem_write_enable immediately; that write is not guaranteed.
//   - io_accum returns to 0.
// TESTING
//   1 Hold rst_n=0, release; then pulse rst_n=0 during RD_WAIT
//     -> all outputs 0, req_ready=1, and no rsp_valid pulse follows.
//   2 Store 0xDEADBEEF @0x00005, then load @0x00005
//     -> mem_write_enable high exactly 1 cycle with mem_address=5; store rsp at N=2.
//     -> load returns rsp_rdata=0xDEADBEEF at N=3.
//   3 Load @0x00000 from the initialised RAM model -> rsp_rdata=0x1800FFFF at N=3; mem_write_enable stays 0.
//   4 io_switches=0x00A5, wait 2 cycles, load @0x01000 -> 0x000000A5 at N=1.
//     io_buttons=4'b1000, load @0x01001 -> 0x00000008.
//   5 Store 7 @0x01002, then load @0x01002
//     -> io_accum=7 and rsp_rdata=7; mem_address unchanged; mem_write_enable never asserted.
//   6 Load and store @0x00400 (=MEM_SIZE), with req_valid held high back-to-back
//     -> rsp_rdata=0, no RAM strobe; each request accepted only while req_ready=1.

Source files
------------

// File: rtl/mem_bus_master.sv
// Bus initiator between the CPU load/store path and a synchronous block RAM,
// with a small memory-mapped I/O window (switches, buttons, accumulator).
module mem_bus_master #(
    parameter int          MEM_SIZE  = 1024,
    parameter logic [19:0] IO_BASE   = 20'h01000,
    parameter int          SW_WIDTH  = 16,
    parameter int          BTN_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [19:0]          req_address,
    input  logic [31:0]          req_wdata,
    output logic                 rsp_valid,
    output logic [31:0]          rsp_rdata,
    output logic [19:0]          mem_address,
    output logic [31:0]          mem_write_value,
    output logic                 mem_write_enable,
    input  logic [31:0]          mem_read_value,
    input  logic [SW_WIDTH-1:0]  io_switches,
    input  logic [BTN_WIDTH-1:0] io_buttons,
    output logic [31:0]          io_accum
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ISSUE,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [19:0] MEM_LIMIT = 20'(MEM_SIZE);

    state_t               state, state_next;
    logic [SW_WIDTH-1:0]  sw_meta, sw_sync;
    logic [BTN_WIDTH-1:0] btn_meta, btn_sync;

    logic [19:0] mem_address_next;
    logic [31:0] mem_write_value_next;
    logic        mem_write_enable_next;
    logic        rsp_valid_next;
    logic [31:0] rsp_rdata_next;
    logic [31:0] io_accum_next;

    logic is_ram, is_sw, is_btn, is_acc;

    assign req_ready = (state == IDLE);
    assign is_ram    = (req_address < MEM_LIMIT);
    assign is_sw     = (req_address == IO_BASE);
    assign is_btn    = (req_address == IO_BASE + 20'd1);
    assign is_acc    = (req_address == IO_BASE + 20'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            sw_meta          <= '0;
            sw_sync          <= '0;
            btn_meta         <= '0;
            btn_sync         <= '0;
            mem_address      <= '0;
            mem_write_value  <= '0;
            mem_write_enable <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            io_accum         <= '0;
        end else begin
            state            <= state_next;
            sw_meta          <= io_switches;
            sw_sync          <= sw_meta;
            btn_meta         <= io_buttons;
            btn_sync         <= btn_meta;
            mem_address      <= mem_address_next;
            mem_write_value  <= mem_write_value_next;
            mem_write_enable <= mem_write_enable_next;
            rsp_valid        <= rsp_valid_next;
            rsp_rdata        <= rsp_rdata_next;
            io_accum         <= io_accum_next;
        end
    end

    // Every output except req_ready is registered, so this block computes
    // the value each output register takes at the next edge.
    always_comb begin
        state_next            = state;
        mem_address_next      = mem_address;
        mem_write_value_next  = mem_write_value;
        mem_write_enable_next = 1'b0;
        rsp_valid_next        = 1'b0;
        rsp_rdata_next        = rsp_rdata;
        io_accum_next         = io_accum;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (is_ram) begin
                        mem_address_next = req_address;
                        if (req_write) begin
                            mem_write_value_next  = req_wdata;
                            mem_write_enable_next = 1'b1;
                            rsp_rdata_next        = '0;
                            state_next            = WR;
                        end else begin
                            state_next = RD_ISSUE;
                        end
                    end else begin
                        // IO and unmapped accesses complete without touching the RAM
                        rsp_rdata_next = '0;
                        rsp_valid_next = 1'b1;
                        state_next     = RESP;
                        if (!req_write) begin
                            if (is_sw)
                                rsp_rdata_next = 32'(sw_sync);
                            else if (is_btn)
                                rsp_rdata_next = 32'(btn_sync);
                            else if (is_acc)
                                rsp_rdata_next = io_accum;
                        end else if (is_acc) begin
                            io_accum_next = req_wdata;
                        end
                    end
                end
            end
            WR: begin
                rsp_valid_next = 1'b1;
                state_next     = RESP;
            end
            RD_ISSUE: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                rsp_rdata_next = mem_read_value;
                rsp_valid_next = 1'b1;
                state_next     = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: vector table plus a response
// scoreboard, with a behavioural 1-cycle-latency RAM model.
module tb_mem_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [19:0] req_address;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [19:0] mem_address;
    logic [31:0] mem_write_value;
    logic        mem_write_enable;
    logic [31:0] mem_read_value;
    logic [15:0] io_switches;
    logic [3:0]  io_buttons;
    logic [31:0] io_accum;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int rsp_cnt = 0;

    typedef struct {
        logic [31:0] rdata;
        int          acc;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        bit          write;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          lat;
        int          we;
        logic [19:0] maddr;
        logic [31:0] accum;
    } vec_t;
    vec_t vecs[13];

    logic [31:0] ram [0:1023];

    mem_bus_master dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .mem_address     (mem_address),
        .mem_write_value (mem_write_value),
        .mem_write_enable(mem_write_enable),
        .mem_read_value  (mem_read_value),
        .io_switches     (io_switches),
        .io_buttons      (io_buttons),
        .io_accum        (io_accum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: write and registered read share one address port
    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 32'(i) * 32'h00010001;
        ram[0] = 32'h1800FFFF;
    end

    always @(posedge clk) begin
        if (mem_write_enable) ram[mem_address[9:0]] <= mem_write_value;
        mem_read_value <= ram[mem_address[9:0]];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Response scoreboard and write-strobe monitor
    always @(negedge clk) begin
        if (rst_n && mem_write_enable) begin
            we_cnt++;
            checkOutput("we_addr_in_ram", 32'(mem_address < 20'd1024), 32'd1);
        end
        if (rst_n && rsp_valid) begin
            exp_t e;
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp actual=rsp_valid=1 required=rsp_valid=0");
            end else begin
                e = exp_q.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                checkOutput("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic applyStimulus(input bit write, input logic [19:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata, input int lat, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        req_valid   = 1'b1;
        req_write   = write;
        req_address = addr;
        req_wdata   = wdata;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=req_ready=0 required=req_ready=1");
        end else begin
            e.rdata = exp_rdata;
            e.acc   = cyc;
            e.lat   = lat;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!(exp_q.size() == 0 && req_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0 || !req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout actual=pending=%0d required=pending=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        checkOutput({tag, "_mem_address"}, 32'(mem_address), 32'd0);
        checkOutput({tag, "_mem_write_value"}, mem_write_value, 32'd0);
        checkOutput({tag, "_mem_write_enable"}, 32'(mem_write_enable), 32'd0);
        checkOutput({tag, "_io_accum"}, io_accum, 32'd0);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int we_before, rsp_before;

        vecs[0]  = '{1'b0, 20'h00000, 32'h0,        32'h1800FFFF, 3, 0, 20'h00000, 32'd0};
        vecs[1]  = '{1'b1, 20'h00005, 32'hDEADBEEF, 32'h0,        2, 1, 20'h00005, 32'd0};
        vecs[2]  = '{1'b0, 20'h00005, 32'h0,        32'hDEADBEEF, 3, 0, 20'h00005, 32'd0};
        vecs[3]  = '{1'b1, 20'h003FF, 32'h12345678, 32'h0,        2, 1, 20'h003FF, 32'd0};
        vecs[4]  = '{1'b0, 20'h003FF, 32'h0,        32'h12345678, 3, 0, 20'h003FF, 32'd0};
        vecs[5]  = '{1'b0, 20'h01000, 32'h0,        32'h000000A5, 1, 0, 20'h003FF, 32'd0};
        vecs[6]  = '{1'b0, 20'h01001, 32'h0,        32'h00000008, 1, 0, 20'h003FF, 32'd0};
        vecs[7]  = '{1'b1, 20'h01002, 32'h7,        32'h0,        1, 0, 20'h003FF, 32'd7};
        vecs[8]  = '{1'b0, 20'h01002, 32'h0,        32'h00000007, 1, 0, 20'h003FF, 32'd7};
        vecs[9]  = '{1'b1, 20'h01000, 32'h0000FFFF, 32'h0,        1, 0, 20'h003FF, 32'd7};
        vecs[10] = '{1'b0, 20'h01000, 32'h0,        32'h000000A5, 1, 0, 20'h003FF, 32'd7};
        vecs[11] = '{1'b0, 20'h01003, 32'h0,        32'h0,        1, 0, 20'h003FF, 32'd7};
        vecs[12] = '{1'b0, 20'hFFFFF, 32'h0,        32'h0,        1, 0, 20'h003FF, 32'd7};

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_address = '0;
        req_wdata   = '0;
        io_switches = '0;
        io_buttons  = '0;

        repeat (3) @(negedge clk);
        checkReset("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        checkReset("after_release");

        io_switches = 16'h00A5;
        io_buttons  = 4'b1000;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            we_before = we_cnt;
            applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].lat, 1'b0);
            waitIdle();
            checkOutput($sformatf("v%0d_we_count", i), 32'(we_cnt - we_before), 32'(vecs[i].we));
            checkOutput($sformatf("v%0d_mem_address", i), 32'(mem_address), 32'(vecs[i].maddr));
            checkOutput($sformatf("v%0d_io_accum", i), io_accum, vecs[i].accum);
        end
        checkOutput("mem_write_value_hold", mem_write_value, 32'h12345678);

        // Back-to-back requests to MEM_SIZE with req_valid never dropped
        we_before  = we_cnt;
        rsp_before = rsp_cnt;
        applyStimulus(1'b0, 20'h00400, 32'h0,        32'h0, 1, 1'b1);
        applyStimulus(1'b1, 20'h00400, 32'hCAFEF00D, 32'h0, 1, 1'b1);
        applyStimulus(1'b0, 20'h00400, 32'h0,        32'h0, 1, 1'b0);
        waitIdle();
        checkOutput("b2b_we_count", 32'(we_cnt - we_before), 32'd0);
        checkOutput("b2b_rsp_count", 32'(rsp_cnt - rsp_before), 32'd3);
        checkOutput("b2b_mem_address", 32'(mem_address), 32'h003FF);

        // Reset pulse while a RAM load sits in RD_WAIT must abort it silently
        rsp_before = rsp_cnt;
        applyStimulus(1'b0, 20'h00005, 32'h0, 32'hDEADBEEF, 3, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        checkReset("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("abort_rsp_count", 32'(rsp_cnt - rsp_before), 32'd0);
        checkReset("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
